// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel packer: write-FSM states,
// screen geometry and the 64-bit word entry carried through the word FIFO.
package fb_pkg;

  localparam int FB_WIDTH  = 720;
  localparam int FB_HEIGHT = 480;
  localparam int ADDR_W    = 29;
  localparam int WORD_W    = 64;
  localparam int BE_W      = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic [BE_W-1:0]   be;
  } fb_word_t;

  // 64-bit mask covering the byte lane a pixel column lands in.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [2:0] lane);
    return {56'd0, 8'hFF} << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Single-clock show-ahead FIFO of packed framebuffer words; head entry is
// visible on o_rdata whenever o_empty is low.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_sys,
  input  logic     reset_n,
  input  logic     i_push,
  input  fb_word_t i_wdata,
  input  logic     i_pop,
  output fb_word_t o_rdata,
  output logic     o_full,
  output logic     o_empty,
  output logic     o_afull
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 1);

  fb_word_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_cnt;
  logic            w_wr;
  logic            w_rd;

  assign o_full  = (r_cnt == CNT_FULL);
  assign o_afull = (r_cnt == CNT_AFULL);
  assign o_empty = (r_cnt == '0);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fb_packer.sv
// Packs 8-bit palette pixels into 64-bit framebuffer words and writes them to a
// DDRAM channel. Optional statistics counters are built when FB_PACKER_STATS_EN is defined.
module fb_packer
  import fb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [28:0] BASE_WADDR = 29'h0600000,
  parameter int          STRIDE_W   = 90
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [7:0]  pix_color,
  output logic [28:0] fb_addr,
  output logic [63:0] fb_data,
  output logic [7:0]  fb_be,
  output logic        fb_req,
  input  logic        fb_ready
`ifdef FB_PACKER_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] word_cnt
`endif
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pending word under assembly, keyed by row and 8-pixel column group.
  logic [15:0] r_pend_key;
  logic [28:0] r_pend_addr;
  logic [63:0] r_pend_data;
  logic [7:0]  r_pend_be;
  logic        r_fowed;

  wr_state_e   r_state;
  logic        r_fb_req;
  logic [28:0] r_fb_addr;
  logic [63:0] r_fb_data;
  logic [7:0]  r_fb_be;

  logic        w_full;
  logic        w_afull;
  logic        w_empty;
  logic        w_acc;
  logic        w_need;
  logic        w_push;
  logic        w_pop;
  logic        w_pend_nz;
  logic [15:0] w_key;
  logic [28:0] w_addr;
  logic [63:0] w_byte_data;
  logic [63:0] w_byte_mask;
  logic [7:0]  w_byte_be;
  fb_word_t    w_wr_word;
  fb_word_t    w_rd_word;

  assign w_key       = {pix_y, pix_x[9:3]};
  assign w_addr      = BASE_WADDR + 29'(pix_y) * 29'(STRIDE_W) + 29'(pix_x[9:3]);
  assign w_byte_mask = lane_mask(pix_x[2:0]);
  assign w_byte_data = {56'd0, pix_color} << {pix_x[2:0], 3'b000};
  assign w_byte_be   = 8'b1 << pix_x[2:0];
  assign w_pend_nz   = (r_pend_be != 8'd0);

  // Refusing pixels one word early keeps room for the owed flush plus its successor.
  assign pix_ready = reset_n & ~w_full & ~(w_afull & r_fowed);
  assign w_acc     = pix_valid & pix_ready;
  assign w_need    = w_pend_nz & (r_fowed | frame_start | (w_acc & (w_key != r_pend_key)));
  assign w_push    = w_need & ~w_full;
  assign w_pop     = (r_state == ST_REQ) & fb_ready;

  assign w_wr_word.addr = r_pend_addr;
  assign w_wr_word.data = r_pend_data;
  assign w_wr_word.be   = r_pend_be;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_key  <= '0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_pend_be   <= '0;
      r_fowed     <= 1'b0;
    end else if (w_acc) begin
      r_fowed <= (pix_x[2:0] == 3'd7);
      if (w_push || !w_pend_nz) begin
        r_pend_key  <= w_key;
        r_pend_addr <= w_addr;
        r_pend_data <= w_byte_data;
        r_pend_be   <= w_byte_be;
      end else begin
        r_pend_data <= (r_pend_data & ~w_byte_mask) | w_byte_data;
        r_pend_be   <= r_pend_be | w_byte_be;
      end
    end else if (w_push) begin
      r_pend_be <= '0;
      r_fowed   <= 1'b0;
    end else if (frame_start && w_pend_nz) begin
      // FIFO full at the frame boundary: remember the flush until space frees up.
      r_fowed <= 1'b1;
    end
  end

  fb_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_wr_word),
    .i_pop   (w_pop),
    .o_rdata (w_rd_word),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_afull (w_afull)
  );

  // Write FSM: outputs are latched from the FIFO head and held until acknowledged.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_fb_req  <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_fb_be   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state   <= ST_REQ;
            r_fb_req  <= 1'b1;
            r_fb_addr <= w_rd_word.addr;
            r_fb_data <= w_rd_word.data;
            r_fb_be   <= w_rd_word.be;
          end
        end
        ST_REQ: begin
          if (fb_ready) begin
            r_state  <= ST_IDLE;
            r_fb_req <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_fb_req <= 1'b0;
        end
      endcase
    end
  end

  assign fb_req  = r_fb_req;
  assign fb_addr = r_fb_addr;
  assign fb_data = r_fb_data;
  assign fb_be   = r_fb_be;

`ifdef FB_PACKER_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else if (frame_start) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      if (pix_valid && !pix_ready) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_pop) begin
        r_word_cnt <= sat_inc(r_word_cnt);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign word_cnt  = r_word_cnt;
`endif

endmodule

// File: tb/tb_fb_packer.sv
// Randomised and directed bench for fb_packer against a word-level reference model
// that turns the accepted pixel stream into the expected sequence of DDRAM writes.
module tb_fb_packer;

  localparam int          DEPTH  = 4;
  localparam logic [28:0] BASE   = 29'h0600000;
  localparam int          STRIDE = 90;

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid   = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x       = '0;
  logic [8:0]  pix_y       = '0;
  logic [7:0]  pix_color   = '0;
  logic [28:0] fb_addr;
  logic [63:0] fb_data;
  logic [7:0]  fb_be;
  logic        fb_req;
  logic        fb_ready    = 1'b0;
`ifdef FB_PACKER_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] word_cnt;
`endif

  fb_packer #(
    .FIFO_DEPTH (DEPTH),
    .BASE_WADDR (BASE),
    .STRIDE_W   (STRIDE)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_be       (fb_be),
    .fb_req      (fb_req),
    .fb_ready    (fb_ready)
`ifdef FB_PACKER_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .word_cnt    (word_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wrd_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  wrd_t exp_q[$];
  wrd_t got_q[$];

  // Reference pending word: row, column group, bytes and lanes written so far.
  int          m_y  = 0;
  int          m_wx = 0;
  logic [63:0] m_d  = '0;
  logic [7:0]  m_be = '0;

  bit          hold_prev = 1'b0;
  logic [28:0] p_a;
  logic [63:0] p_d;
  logic [7:0]  p_be;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_flush();
    wrd_t w;
    if (m_be != 8'h00) begin
      w.a  = 29'(int'(BASE) + m_y * STRIDE + m_wx);
      w.d  = m_d;
      w.be = m_be;
      exp_q.push_back(w);
    end
    m_be = '0;
    m_d  = '0;
  endfunction

  function automatic void m_pixel(input int x, input int y, input int c);
    int wx;
    int n;
    wx = x / 8;
    n  = x % 8;
    if (m_be != 8'h00 && (wx != m_wx || y != m_y)) m_flush();
    m_y  = y;
    m_wx = wx;
    m_d[n*8 +: 8] = 8'(c);
    m_be[n] = 1'b1;
    if (n == 7) m_flush();
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, predict the next rising edge.
  task automatic tick(input bit fs, input bit v, input int x, input int y, input int c,
                      input bit rdy, output bit acc);
    wrd_t e;
    wrd_t g;
    @(negedge clk_sys);
    frame_start = fs;
    pix_valid   = v;
    pix_x       = 10'(x);
    pix_y       = 9'(y);
    pix_color   = 8'(c);
    fb_ready    = rdy;
    #1;
    acc = v && (pix_ready === 1'b1);
    if (hold_prev) begin
      check("hold_req", 64'(fb_req), 64'd1);
      check("hold_addr", 64'(fb_addr), 64'(p_a));
      check("hold_data", fb_data, p_d);
      check("hold_be", 64'(fb_be), 64'(p_be));
    end
    if (fb_req && fb_ready) begin
      hs_cnt++;
      g.a  = fb_addr;
      g.d  = fb_data;
      g.be = fb_be;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        check("extra_write", 64'(fb_req && fb_ready), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(fb_addr), 64'(e.a));
        check("wr_data", fb_data, e.d);
        check("wr_be", 64'(fb_be), 64'(e.be));
      end
    end
    if (fs) m_flush();
    if (acc) m_pixel(x, y, c);
    hold_prev = fb_req && !fb_ready;
    p_a  = fb_addr;
    p_d  = fb_data;
    p_be = fb_be;
  endtask

  task automatic send(input int x, input int y, input int c, input bit rdy);
    bit a;
    int k;
    a = 1'b0;
    k = 0;
    while (!a && k < 200) begin
      tick(1'b0, 1'b1, x, y, c, rdy, a);
      k++;
    end
    if (!a) check("send_accept", 64'(a), 64'd1);
  endtask

  task automatic drain(input int budget);
    bit a;
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fb_req) && k < budget) begin
      tick(1'b0, 1'b0, 0, 0, 0, 1'b1, a);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (6) tick(1'b0, 1'b0, 0, 0, 0, 1'b1, a);
  endtask

  initial begin
    bit a;
    bit fs;
    bit v;
    bit r;
    int idx;
    int k;
    int stall_at;
    int cx;
    int cy;
    int hs0;
    int stalls;

    // Reset state
    #1;
    check("rst_req", 64'(fb_req), 64'd0);
    check("rst_addr", 64'(fb_addr), 64'd0);
    check("rst_data", fb_data, 64'd0);
    check("rst_be", 64'(fb_be), 64'd0);
    check("rst_ready", 64'(pix_ready), 64'd0);
    #20;
    @(negedge clk_sys);
    reset_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(pix_ready), 64'd1);

    // One full word, acknowledge always high
    got_q.delete();
    for (int i = 0; i < 8; i++) send(i, 0, i + 1, 1'b1);
    drain(200);
    check("w0_count", 64'(got_q.size()), 64'd1);
    check("w0_addr", 64'(got_q[0].a), 64'(BASE));
    check("w0_data", got_q[0].d, 64'h0807060504030201);
    check("w0_be", 64'(got_q[0].be), 64'hFF);

    // Last word of the last row
    got_q.delete();
    for (int i = 712; i < 720; i++) send(i, 479, 8'hA0 + i - 712, 1'b1);
    drain(200);
    check("corner_addr", 64'(got_q[0].a), 64'(29'(int'(BASE) + 43199)));

    // Partial word closed by a pixel in another word, then by frame_start
    got_q.delete();
    for (int i = 16; i < 19; i++) send(i, 0, i, 1'b1);
    send(40, 0, 8'h77, 1'b1);
    tick(1'b1, 1'b0, 0, 0, 0, 1'b1, a);
    drain(200);
    check("part_count", 64'(got_q.size()), 64'd2);
    check("part0_addr", 64'(got_q[0].a), 64'(BASE + 29'd2));
    check("part0_be", 64'(got_q[0].be), 64'h07);
    check("part1_addr", 64'(got_q[1].a), 64'(BASE + 29'd5));
    check("part1_be", 64'(got_q[1].be), 64'h01);

    // frame_start together with an accepted pixel
    got_q.delete();
    for (int i = 0; i < 3; i++) send(i, 5, 8'h30 + i, 1'b1);
    tick(1'b1, 1'b1, 3, 5, 8'h33, 1'b1, a);
    check("fs_pix_accept", 64'(a), 64'd1);
    for (int i = 4; i < 8; i++) send(i, 5, 8'h30 + i, 1'b1);
    drain(200);
    check("fs_count", 64'(got_q.size()), 64'd2);
    check("fs0_be", 64'(got_q[0].be), 64'h07);
    check("fs1_be", 64'(got_q[1].be), 64'hF8);
    check("fs1_addr", 64'(got_q[1].a), 64'(29'(int'(BASE) + 5 * STRIDE)));

    // Full line streamed with the acknowledge withheld for 100 cycles
    got_q.delete();
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, a);
    idx = 0;
    stall_at = -1;
    for (int c = 0; c < 100; c++) begin
      tick(1'b0, idx < 720, idx, 3, (idx * 7 + 3) & 255, 1'b0, a);
      if (a) idx++;
      if (!pix_ready && stall_at < 0) stall_at = idx;
    end
    check("stall_point", 64'(stall_at), 64'(8 * DEPTH));
    check("held_accepts", 64'(idx), 64'(8 * DEPTH));
    k = 0;
    while (idx < 720 && k < 5000) begin
      tick(1'b0, 1'b1, idx, 3, (idx * 7 + 3) & 255, 1'b1, a);
      if (a) idx++;
      k++;
    end
    drain(2000);
    check("line_count", 64'(got_q.size()), 64'd90);
    for (int i = 0; i < 90 && i < got_q.size(); i++) begin
      check("line_order", 64'(got_q[i].a), 64'(29'(int'(BASE) + 3 * STRIDE + i)));
    end

    // Randomised traffic
    cx = 0;
    cy = 0;
    for (int i = 0; i < 800; i++) begin
      fs = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      r  = 1'($urandom_range(0, 1));
      tick(fs, v, cx, cy, int'($urandom_range(0, 255)), r, a);
      if (a) begin
        if ($urandom_range(0, 7) == 0) begin
          cx = int'($urandom_range(0, 719));
          cy = int'($urandom_range(0, 479));
        end else begin
          cx++;
          if (cx == 720) begin
            cx = 0;
            cy = (cy + 1) % 480;
          end
        end
      end
    end
    tick(1'b1, 1'b0, 0, 0, 0, 1'b1, a);
    drain(2000);

    // Reset while a request is outstanding
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, a);
    for (int i = 0; i < 8; i++) send(i, 0, 8'h50 + i, 1'b0);
    k = 0;
    while (!fb_req && k < 20) begin
      tick(1'b0, 1'b0, 0, 0, 0, 1'b0, a);
      k++;
    end
    check("mid_req_seen", 64'(fb_req), 64'd1);
    @(negedge clk_sys);
    #2;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    fb_ready    = 1'b0;
    #1;
    check("mid_rst_req", 64'(fb_req), 64'd0);
    check("mid_rst_be", 64'(fb_be), 64'd0);
    check("mid_rst_ready", 64'(pix_ready), 64'd0);
    exp_q.delete();
    m_be = '0;
    m_d  = '0;
    hold_prev = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 0, 0, 0, 1'b1, a);
      check("post_rst_idle", 64'(fb_req), 64'd0);
    end
    got_q.delete();
    tick(1'b1, 1'b0, 0, 0, 0, 1'b1, a);
    for (int i = 0; i < 8; i++) send(i, 1, 8'h10 + i, 1'b1);
    drain(200);
    check("post_rst_addr", 64'(got_q[0].a), 64'(29'(int'(BASE) + STRIDE)));
    check("post_rst_data", got_q[0].d, 64'h1716151413121110);

`ifdef FB_PACKER_STATS_EN
    // Statistics: ten stalled cycles, handshakes, clear on frame_start
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, a);
    idx = 0;
    stalls = 0;
    k = 0;
    while (stalls < 10 && k < 300) begin
      tick(1'b0, 1'b1, idx, 10, idx & 255, 1'b0, a);
      if (a) idx++;
      else stalls++;
      k++;
    end
    tick(1'b0, 1'b0, 0, 0, 0, 1'b0, a);
    check("stall_cnt", 64'(stall_cnt), 64'd10);
    check("word_cnt_held", 64'(word_cnt), 64'd0);
    hs0 = hs_cnt;
    repeat (6) tick(1'b0, 1'b0, 0, 0, 0, 1'b1, a);
    tick(1'b0, 1'b0, 0, 0, 0, 1'b0, a);
    check("word_cnt", 64'(word_cnt), 64'(hs_cnt - hs0));
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, a);
    tick(1'b0, 1'b0, 0, 0, 0, 1'b0, a);
    check("stall_cnt_clr", 64'(stall_cnt), 64'd0);
    check("word_cnt_clr", 64'(word_cnt), 64'd0);
    drain(2000);
`endif

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_packer.md
FB_PACKER -- requirements
Module: fb_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: depth of the word FIFO in 64-bit entries; power of two, minimum 2.
REQ-002 SHALL have parameter BASE_WADDR, default 29'h0600000: framebuffer base as a DDRAM 64-bit word address.
REQ-003 SHALL have parameter STRIDE_W, default 90: line stride in 64-bit words (720 bytes).
REQ-004 SHALL have port clk_sys, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port frame_start, input, 1: one-cycle pulse marking the start of a frame.
REQ-007 SHALL have port pix_valid, input, 1: pixel present this cycle.
REQ-008 SHALL have port pix_ready, output, 1: pixel accepted when pix_valid and pix_ready are both high.
REQ-009 SHALL have port pix_x, input, 10: pixel column, 0..719.
REQ-010 SHALL have port pix_y, input, 9: pixel row, 0..479.
REQ-011 SHALL have port pix_color, input, 8: palette index.
REQ-012 SHALL have port fb_addr, output, 29: DDRAM word address.
REQ-013 SHALL have port fb_data, output, 64: packed pixels, byte n = column 8k+n.
REQ-014 SHALL have port fb_be, output, 8: byte enables.
REQ-015 SHALL have port fb_req, output, 1: write request.
REQ-016 SHALL have port fb_ready, input, 1: one-cycle acknowledge from the DDRAM channel.

Function
REQ-017 SHALL assemble accepted pixels into a pending word identified by (pix_y, pix_x[9:3]) and write byte pix_x[2:0] while setting its be bit.
REQ-018 SHALL flush the pending word to the FIFO in the cycle after the pixel with pix_x[2:0]==7 is accepted, i.e. FIFO write at N+1.
REQ-019 SHALL flush the pending word first, then start a new word with the incoming pixel, when an accepted pixel belongs to a different word than the non-empty pending word.
REQ-020 SHALL flush any non-empty pending word on frame_start; an empty pending word (be==0) SHALL never be pushed.
REQ-021 SHALL compute the word address as BASE_WADDR + pix_y*STRIDE_W + pix_x[9:3], modulo 2^29.
REQ-022 SHALL drive pix_ready = 0 whenever the FIFO is full, or is full-minus-one with a flush pending, so that no pixel or word is ever dropped.
REQ-023 SHALL implement the write FSM with states IDLE and REQ:
- IDLE goes to REQ when the FIFO is non-empty, raising fb_req in the cycle after the FIFO becomes non-empty.
- REQ holds fb_req, fb_addr, fb_data and fb_be stable until fb_ready is sampled high, then pops the FIFO and returns to IDLE.
- fb_ready outside REQ is ignored.
REQ-024 SHALL accept a simultaneous FIFO push and pop in the same cycle, leaving the occupancy unchanged.
REQ-025 SHALL, when frame_start coincides with an accepted pixel, flush the old pending word first and treat the pixel as the first pixel of the new frame.

Reset
REQ-026 SHALL, on reset_n low, asynchronously drive fb_req=0, fb_addr=0, fb_data=0, fb_be=0, pix_ready=0, FIFO empty, pending be=0 and FSM=IDLE.
REQ-027 SHALL drive pix_ready=1 in the first cycle after reset_n deasserts.
REQ-028 SHALL, when reset is asserted mid-request, discard the outstanding request without completing it.

Configuration
REQ-029 SHALL, when FB_PACKER_STATS_EN is defined, add outputs stall_cnt (16 bits) and word_cnt (16 bits):
- stall_cnt counts cycles with pix_valid & ~pix_ready.
- word_cnt counts completed fb_ready handshakes.
- Both saturate at 16'hFFFF and clear on frame_start and on reset.
REQ-030 SHALL, when FB_PACKER_STATS_EN is not defined, omit these ports and counters with no other behavioural change.

Structure
REQ-031 SHALL place the FSM state enum, FB_WIDTH=720, FB_HEIGHT=480 and the word-entry struct {addr, data, be} in shared package fb_pkg.
REQ-032 SHALL implement the FIFO as sub-module fb_word_fifo, a synchronous single-clock FIFO with full/empty flags and the same async active-low reset.

Verification
REQ-033 SHALL cover: pixels x=0..7, y=0 with colors 1..8 and fb_ready tied to 1 -> one write with addr=BASE_WADDR, data=64'h0807060504030201, be=8'hFF.
REQ-034 SHALL cover: pixels x=712..719, y=479 -> addr=BASE_WADDR+479*90+89 = BASE_WADDR+43199.
REQ-035 SHALL cover: pixels x=16..18, then x=40 -> partial word with be=8'h07 at word 2, then the pixel at word 5 with be=8'h01 after frame_start.
REQ-036 SHALL cover: fb_ready held low for 100 cycles while a full line is streamed -> pix_ready falls after FIFO_DEPTH words, nothing is lost, fb_addr/fb_data stay stable; 90 words in order after release.
REQ-037 SHALL cover: reset_n pulsed low while fb_req is high -> fb_req=0 immediately and FIFO empty; the next frame's first write is correct.
REQ-038 SHALL cover, with FB_PACKER_STATS_EN: a 10-cycle stall gives stall_cnt=10; after frame_start both counters read 0.
